pipe_skid_buf32: RTL and testbench

- Two-entry skid buffer (pipeline latch) sitting directly downstream of the 32-bit 2:1 operand/result select mux.
- Registers the mux output and decouples the producing stage from a back-pressuring consumer.
- Sustains full throughput with a fully registered ready path toward the producer.
- Used at stage boundaries where the downstream stage can stall or be flushed.

---
 rtl/pipe_skid_buf32.sv | 113 +++++++++++
 tb/tb_pipe_skid_buf32.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf32.sv
// Two-entry skid buffer behind the 32-bit select mux: registered output, registered ready.
// Optional stall counter (stall_cnt port) is enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_buf32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_data_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             main_valid_q;
  logic             in_ready_q;
  logic [1:0]       occ_q;

  logic in_fire;
  logic out_fire;

  // Both handshakes only look at flops on the buffer side, so in_ready never depends on out_ready.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

  // Skid data is never reset; an invalid entry simply keeps its stale payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else if (flush) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q      <= StOne;
            main_data_q  <= in_data;
            main_valid_q <= 1'b1;
            occ_q        <= 2'd1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
          end else if (in_fire) begin
            state_q     <= StTwo;
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            occ_q       <= 2'd2;
          end else if (out_fire) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            occ_q        <= 2'd0;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_q     <= StOne;
            main_data_q <= skid_data_q;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        default: begin
          state_q      <= StEmpty;
          main_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
          occ_q        <= 2'd0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (main_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buf32.sv
// Directed self-checking bench for pipe_skid_buf32; stall counter tests run when
// PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_buf32;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;

  pipe_skid_buf32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
      end
      checks++;
      if (out_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_out_data: got %0h expected 0", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
      end
      checks++;
      if (occupancy !== 2'd0) begin
        failures++;
        $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [4];
    vec[0] = 32'hDEADBEEF;
    vec[1] = 32'h1;
    vec[2] = 32'h2;
    vec[3] = 32'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vec[i]) begin
        failures++;
        $display("FAIL stream_data[%0d]: got v=%0b d=%0h expected v=1 d=%0h",
                 i, out_valid, out_data, vec[i]);
      end
      checks++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%0b expected occ=1 rdy=1",
                 i, occupancy, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      failures++;
      $display("FAIL bp_full: got occ=%0d rdy=%0b d=%0h expected occ=2 rdy=0 d=a",
               occupancy, in_ready, out_data);
    end
    step();
    checks++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      failures++;
      $display("FAIL bp_hold: got occ=%0d v=%0b d=%0h expected occ=2 v=1 d=a",
               occupancy, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop1: got d=%0h occ=%0d rdy=%0b expected d=b occ=1 rdy=1",
               out_data, occupancy, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL bp_pop2: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD0;
    step();
    in_data = 32'hD1;
    step();
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL flush_setup: got occ=%0d expected 2", occupancy);
    end
    flush   = 1'b1;
    in_data = 32'hC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got occ=%0d v=%0b rdy=%0b expected occ=0 v=0 rdy=1",
               occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_c[%0d]: got v=%0b d=%0h expected v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h7;
    step();
    in_data = 32'h8;
    step();
    rst     = 1'b1;
    in_data = 32'h9;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid: got v=%0b d=%0h rdy=%0b occ=%0d expected v=0 d=0 rdy=1 occ=0",
               out_valid, out_data, in_ready, occupancy);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL rst_push5: got v=%0b d=%0h occ=%0d expected v=1 d=5 occ=1",
               out_valid, out_data, occupancy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rst_alone: got v=%0b d=%0h occ=%0d expected v=0 occ=0",
               out_valid, out_data, occupancy);
    end
  endtask

`ifdef PIPE_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_reset: got %0d expected 0", stall_cnt);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++;
      $display("FAIL stall_ten: got %0d expected 10", stall_cnt);
    end
    // Consume in the flush cycle so no new stall cycle is added.
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++;
      $display("FAIL stall_flush: got %0d expected 10", stall_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_rst: got %0d expected 0", stall_cnt);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h22;
    step();
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_sat: got %0h expected ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef PIPE_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
